// File: rtl/canvas_pkg.sv
// canvas_pkg: shared canvas geometry defaults, stroke record and scheduler states
package canvas_pkg;
  localparam int CANVAS_H_PIXELS = 320;
  localparam int CANVAS_V_PIXELS = 180;
  localparam int CANVAS_ADDR_W = 16;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] color;
    logic [2:0] sw;
  } stroke_t;
  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_e;
endpackage

// File: rtl/canvas_write_scheduler_brush_scan.sv
// brush_scan: walks an SxS brush around a latched origin, flags off-canvas pixels
module brush_scan
  import canvas_pkg::*;
#(
  parameter int H_PIXELS = CANVAS_H_PIXELS,
  parameter int V_PIXELS = CANVAS_V_PIXELS
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_i,
  input  logic       step_i,
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  input  logic [2:0] sw_i,
  output logic       valid_o,
  output logic [9:0] px_o,
  output logic [8:0] py_o,
  output logic       last_o
);
  logic [10:0] ox_q, ox_d;
  logic [9:0] oy_q, oy_d;
  logic [2:0] sw_q, sw_d, dx_q, dx_d, dy_q, dy_d;
  logic [11:0] px;
  logic [10:0] py;
  logic row_end;
  always_comb begin
    row_end = dx_q == sw_q;
    px = {ox_q[10], ox_q} + {9'd0, dx_q};
    py = {oy_q[9], oy_q} + {8'd0, dy_q};
    valid_o = !px[11] && px[10:0] < 11'(H_PIXELS) && !py[10] && py[9:0] < 10'(V_PIXELS);
    px_o = px[9:0];
    py_o = py[8:0];
    last_o = row_end && dy_q == sw_q;
    ox_d = start_i ? {1'b0, x_i} - 11'(sw_i[2:1]) : ox_q;
    oy_d = start_i ? {1'b0, y_i} - 10'(sw_i[2:1]) : oy_q;
    sw_d = start_i ? sw_i : sw_q;
    dx_d = (start_i || (step_i && row_end)) ? 3'd0 : step_i ? dx_q + 3'd1 : dx_q;
    dy_d = start_i ? 3'd0 : (step_i && row_end) ? dy_q + 3'd1 : dy_q;
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      ox_q <= '0;
      oy_q <= '0;
      sw_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      ox_q <= ox_d;
      oy_q <= oy_d;
      sw_q <= sw_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
endmodule

// File: rtl/canvas_write_scheduler.sv
// canvas_write_scheduler: arbitrates strokes and clears into one frame-buffer write port
module canvas_write_scheduler
  import canvas_pkg::*;
#(
  parameter int H_PIXELS = CANVAS_H_PIXELS,
  parameter int V_PIXELS = CANVAS_V_PIXELS,
  parameter int ADDR_W = CANVAS_ADDR_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [1:0]            req_valid_in,
  output logic [1:0]            req_ready_out,
  input  logic [1:0][9:0]       req_x_in,
  input  logic [1:0][8:0]       req_y_in,
  input  logic [1:0][3:0]       req_color_in,
  input  logic [1:0][2:0]       req_sw_in,
  input  logic                  clear_in,
  output logic                  wr_en_out,
  output logic [ADDR_W-1:0]     wr_addr_out,
  output logic [3:0]            wr_data_out,
  output logic                  busy_out,
  output logic                  grant_out
);
  localparam int PIX_N = H_PIXELS * V_PIXELS;
  state_e state_q, state_d;
  logic pend_q, pend_d, gnt_q, gnt_d, sel, accept, clr_last;
  logic wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] ccnt_q, ccnt_d, wr_addr_q, wr_addr_d;
  logic [3:0] color_q, color_d, wr_data_q, wr_data_d;
  stroke_t req;
  logic scan_valid, scan_last;
  logic [9:0] px;
  logic [8:0] py;
  brush_scan #(.H_PIXELS(H_PIXELS), .V_PIXELS(V_PIXELS)) u_scan (
    .clk_in(clk_in), .rst_in(rst_in), .start_i(accept), .step_i(state_q == PAINT),
    .x_i(req.x), .y_i(req.y), .sw_i(req.sw),
    .valid_o(scan_valid), .px_o(px), .py_o(py), .last_o(scan_last)
  );
  // round-robin: on a tie the requester not granted last time wins
  always_comb begin
    sel = (&req_valid_in) ? ~gnt_q : req_valid_in[1];
    req = '{x: req_x_in[sel], y: req_y_in[sel], color: req_color_in[sel], sw: req_sw_in[sel]};
    req_ready_out = (state_q == IDLE && !pend_q) ? req_valid_in & (sel ? 2'b10 : 2'b01) : 2'b00;
    accept = |req_ready_out;
    clr_last = ccnt_q == ADDR_W'(PIX_N - 1);
    state_d = state_q == IDLE ? (pend_q ? CLEAR : accept ? PAINT : IDLE) :
              state_q == PAINT ? (scan_last ? IDLE : PAINT) :
              clr_last ? IDLE : CLEAR;
    pend_d = state_q == CLEAR ? pend_q && !clr_last : pend_q || clear_in;
    gnt_d = accept ? sel : gnt_q;
    color_d = accept ? req.color : color_q;
    ccnt_d = state_q == CLEAR ? ccnt_q + 1'b1 : '0;
    wr_en_d = (state_q == PAINT && scan_valid) || state_q == CLEAR;
    wr_addr_d = state_q == PAINT ? ADDR_W'(py) * ADDR_W'(H_PIXELS) + ADDR_W'(px) :
                state_q == CLEAR ? ccnt_q : wr_addr_q;
    wr_data_d = state_q == PAINT ? color_q : state_q == CLEAR ? 4'd0 : wr_data_q;
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      gnt_q <= 1'b1;
      color_q <= '0;
      ccnt_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      gnt_q <= gnt_d;
      color_q <= color_d;
      ccnt_q <= ccnt_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  assign wr_en_out = wr_en_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;
  assign busy_out = state_q != IDLE || pend_q;
  assign grant_out = gnt_q;
endmodule

// File: tb/tb_canvas_write_scheduler.sv
// tb_canvas_write_scheduler: randomized strokes/clears against a pixel-list scoreboard
module tb_canvas_write_scheduler;
  localparam int H = 320, V = 180, N = H * V;
  logic clk_in = 1'b0, rst_in = 1'b0, clear_in = 1'b0;
  logic [1:0] req_valid_in = '0, req_ready_out;
  logic [1:0][9:0] req_x_in = '0;
  logic [1:0][8:0] req_y_in = '0;
  logic [1:0][3:0] req_color_in = '0;
  logic [1:0][2:0] req_sw_in = '0;
  logic wr_en_out, busy_out, grant_out;
  logic [15:0] wr_addr_out;
  logic [3:0] wr_data_out;
  typedef struct {logic [15:0] a; logic [3:0] d;} wr_t;
  wr_t exp_q[$];
  int checks = 0, failures = 0, last_g = 1;

  canvas_write_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_x_in(req_x_in), .req_y_in(req_y_in), .req_color_in(req_color_in), .req_sw_in(req_sw_in),
    .clear_in(clear_in), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out), .busy_out(busy_out), .grant_out(grant_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    wr_t e;
    if (rst_in && wr_en_out) begin
      if (exp_q.size() == 0) chk("extra_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr_out), 32'(e.a));
        chk("wr_data", 32'(wr_data_out), 32'(e.d));
      end
    end
  end

  // reference: every in-canvas pixel of the brush, row-major
  task automatic push_stroke(input int x, input int y, input int c, input int sw);
    for (int dy = 0; dy <= sw; dy++)
      for (int dx = 0; dx <= sw; dx++) begin
        int px, py;
        px = x - sw / 2 + dx;
        py = y - sw / 2 + dy;
        if (px >= 0 && px < H && py >= 0 && py < V) exp_q.push_back('{a: 16'(py * H + px), d: 4'(c)});
      end
  endtask

  task automatic set_req(input int i, input int x, input int y, input int c, input int sw);
    req_x_in[i] = 10'(x);
    req_y_in[i] = 9'(y);
    req_color_in[i] = 4'(c);
    req_sw_in[i] = 3'(sw);
  endtask

  task automatic stroke(input logic [1:0] vm, input int clr_k);
    int g, s;
    g = (vm == 2'b11) ? 1 - last_g : (vm[1] ? 1 : 0);
    s = int'(req_sw_in[g]) + 1;
    req_valid_in = vm;
    @(negedge clk_in);
    chk("ready_idle", 32'(req_ready_out), 32'(1 << g));
    #1 chk("drain", exp_q.size(), 0);
    @(posedge clk_in);
    push_stroke(req_x_in[g], req_y_in[g], req_color_in[g], req_sw_in[g]);
    last_g = g;
    #1;
    req_valid_in[g] = 1'b0;
    set_req(g, $urandom, $urandom, $urandom, $urandom);
    chk("grant", 32'(grant_out), g);
    chk("busy_paint", 32'(busy_out), 1);
    for (int k = 1; k <= s * s; k++) begin
      @(posedge clk_in);
      #1;
      clear_in = (k == clr_k);
      if (k == s * s - 1) chk("ready_low", 32'(req_ready_out), 0);
    end
  endtask

  task automatic wait_clear();
    chk("clear_beats_req", 32'(req_ready_out), 0);
    chk("busy_pending", 32'(busy_out), 1);
    for (int a = 0; a < N; a++) exp_q.push_back('{a: 16'(a), d: 4'd0});
    repeat (N + 1) @(posedge clk_in);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_en", 32'(wr_en_out), 0);
    chk("rst_wr_addr", 32'(wr_addr_out), 0);
    chk("rst_wr_data", 32'(wr_data_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_grant", 32'(grant_out), 1);
    chk("rst_ready", 32'(req_ready_out), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk_in);
    #1 chk_reset_vals();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    set_req(0, 10, 10, 3, 0);
    set_req(1, 20, 20, 4, 1);
    for (int i = 0; i < 4; i++) stroke(2'b11, -1);
    set_req(0, 100, 50, 5, 2);
    stroke(2'b01, -1);
    set_req(1, 0, 0, 9, 3);
    stroke(2'b10, -1);
    set_req(0, 200, 90, 7, 7);
    set_req(1, 5, 6, 12, 0);
    stroke(2'b11, 20);
    wait_clear();
    stroke(2'b10, -1);
    set_req(0, 319, 179, 14, 1);
    stroke(2'b01, -1);
    req_valid_in = '0;
    clear_in = 1'b1;
    @(posedge clk_in);
    #1 clear_in = 1'b0;
    for (int a = 0; a < 1000; a++) exp_q.push_back('{a: 16'(a), d: 4'd0});
    repeat (1001) @(posedge clk_in);
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1 chk_reset_vals();
    chk("rst_drain", exp_q.size(), 0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    last_g = 1;
    for (int i = 0; i < 24; i++) begin
      set_req(0, $urandom_range(0, 330), $urandom_range(0, 190), $urandom, $urandom);
      set_req(1, $urandom_range(0, 330), $urandom_range(0, 190), $urandom, $urandom);
      stroke(2'($urandom_range(1, 3)), -1);
    end
    @(negedge clk_in);
    #1 chk("final_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
